// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that serialises JK command updates from NREQ requesters onto one shared bank.
// Optional grant locking is compiled in with the JK_ARB_LOCK_EN macro.
module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ*WIDTH-1:0]   i_cmd_j,
    input  logic [NREQ*WIDTH-1:0]   i_cmd_k,
    input  logic [NREQ-1:0]         i_lock,
    input  logic                    i_clr,
    output logic [NREQ-1:0]         o_gnt,
    output logic [NREQ-1:0]         o_ack,
    output logic                    o_busy,
    output logic [WIDTH-1:0]        o_q
);

    localparam int IDXW = $clog2(NREQ);
`ifdef JK_ARB_LOCK_EN
    localparam logic LOCK_EN = 1'b1;
`else
    localparam logic LOCK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [IDXW-1:0]   r_ptr;
    logic [IDXW-1:0]   r_gidx;
    logic              r_locked;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_ack;
    logic              r_busy;
    logic [WIDTH-1:0]  r_q;
    logic [WIDTH-1:0]  r_j;
    logic [WIDTH-1:0]  r_k;
    logic [IDXW:0]     w_rr;
    logic              w_sel_valid;
    logic [IDXW-1:0]   w_sel_idx;
    logic              w_lock_hit;
    logic [IDXW-1:0]   w_ptr_next;

    // JK update of a whole vector: 00 hold, 01 clear, 10 set, 11 toggle
    function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] j,
                                                 input logic [WIDTH-1:0] k);
        logic [WIDTH-1:0] n;
        n = q;
        for (int b = 0; b < WIDTH; b++) begin
            case ({j[b], k[b]})
                2'b00:   n[b] = q[b];
                2'b01:   n[b] = 1'b0;
                2'b10:   n[b] = 1'b1;
                2'b11:   n[b] = ~q[b];
                default: n[b] = q[b];
            endcase
        end
        return n;
    endfunction

    // First set request at or after ptr, wrapping; returns {found, index}
    function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [IDXW-1:0] ptr);
        logic            found;
        logic [IDXW-1:0] idx;
        logic [IDXW-1:0] ci;
        int              c;
        found = 1'b0;
        idx   = {IDXW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            c = int'(ptr) + i;
            if (c >= NREQ) c = c - NREQ;
            else           c = c;
            ci = IDXW'(c);
            if (!found && req[ci]) begin
                found = 1'b1;
                idx   = ci;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Arbitration choice, lock detection and next-state decode
    always_comb begin
        w_next      = r_state;
        w_rr        = rr_pick(i_req, r_ptr);
        w_lock_hit  = LOCK_EN & i_lock[r_gidx] & i_req[r_gidx];
        w_ptr_next  = (r_gidx == IDXW'(NREQ - 1)) ? {IDXW{1'b0}} : r_gidx + 1'b1;
        if (r_locked) begin
            w_sel_valid = 1'b1;
            w_sel_idx   = r_gidx;
        end else begin
            w_sel_valid = w_rr[IDXW];
            w_sel_idx   = w_rr[IDXW-1:0];
        end
        case (r_state)
            ST_IDLE:  w_next = w_sel_valid ? ST_APPLY : ST_IDLE;
            ST_APPLY: w_next = ST_ACK;
            ST_ACK:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Sequencer state, grant/ack outputs and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_ptr    <= {IDXW{1'b0}};
            r_gidx   <= {IDXW{1'b0}};
            r_locked <= 1'b0;
            r_gnt    <= {NREQ{1'b0}};
            r_ack    <= {NREQ{1'b0}};
            r_j      <= {WIDTH{1'b0}};
            r_k      <= {WIDTH{1'b0}};
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_valid) begin
                        r_gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << w_sel_idx;
                        r_gidx   <= w_sel_idx;
                        r_j      <= i_cmd_j[w_sel_idx*WIDTH +: WIDTH];
                        r_k      <= i_cmd_k[w_sel_idx*WIDTH +: WIDTH];
                        r_locked <= 1'b0;
                    end else begin
                        r_gnt    <= {NREQ{1'b0}};
                    end
                end
                ST_APPLY: r_ack <= r_gnt;
                ST_ACK: begin
                    r_ack <= {NREQ{1'b0}};
                    r_gnt <= {NREQ{1'b0}};
                    // A held lock keeps ptr in place and re-grants the same requester next
                    if (w_lock_hit) begin
                        r_locked <= 1'b1;
                    end else begin
                        r_locked <= 1'b0;
                        r_ptr    <= w_ptr_next;
                    end
                end
                default: begin
                    r_ack <= {NREQ{1'b0}};
                    r_gnt <= {NREQ{1'b0}};
                end
            endcase
        end
    end

    // Shared bank: clear wins over the JK update
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       r_q <= {WIDTH{1'b0}};
        else if (i_clr)                r_q <= {WIDTH{1'b0}};
        else if (r_state == ST_APPLY)  r_q <= jk_next(r_q, r_j, r_k);
        else                           r_q <= r_q;
    end

    assign o_gnt  = r_gnt;
    assign o_ack  = r_ack;
    assign o_busy = r_busy;
    assign o_q    = r_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed self-checking bench for jk_bank_arbiter (NREQ=4, WIDTH=8).
module tb_jk_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] cmd_j;
    logic [31:0] cmd_k;
    logic [3:0]  lock;
    logic        clr;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        busy;
    logic [7:0]  q;

    int n_tests = 0;
    int n_fail  = 0;

    jk_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .i_req(req), .i_cmd_j(cmd_j), .i_cmd_k(cmd_k),
        .i_lock(lock), .i_clr(clr), .o_gnt(gnt), .o_ack(ack), .o_busy(busy), .o_q(q)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int idx, input logic [7:0] j, input logic [7:0] k);
        cmd_j[idx*8 +: 8] = j;
        cmd_k[idx*8 +: 8] = k;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One full transaction for a single requester, released when ack is seen
    task automatic one_tx(input int idx, input logic [7:0] exp_q, input string tag);
        logic [3:0] oh;
        oh  = 4'b0001 << idx;
        req = oh;
        tick();
        check({tag, "_gnt"}, 32'(gnt), 32'(oh));
        tick();
        check({tag, "_q"},   32'(q),   32'(exp_q));
        check({tag, "_ack"}, 32'(ack), 32'(oh));
        req = 4'b0000;
        tick();
    endtask

    logic [3:0] exp_g;
    logic [3:0] exp_lock [4];

    initial begin
        rst = 1'b1; req = 4'b0000; cmd_j = 32'h0; cmd_k = 32'h0; lock = 4'b0000; clr = 1'b0;
        tick();
        check("rst_gnt",  32'(gnt),  32'h0);
        check("rst_ack",  32'(ack),  32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_q",    32'(q),    32'h0);
        rst = 1'b0;
        tick();

        // JK truth table: F0/3C on 00 -> set 7:6, toggle 5:4, clear 3:2, hold 1:0 = F0
        set_cmd(0, 8'hF0, 8'h3C);
        req = 4'b0001;
        tick();
        check("tt1_gnt",  32'(gnt),  32'h1);
        check("tt1_busy", 32'(busy), 32'h1);
        check("tt1_ack0", 32'(ack),  32'h0);
        tick();
        check("tt1_q",    32'(q),    32'hF0);
        check("tt1_ack",  32'(ack),  32'h1);
        req = 4'b0000;
        tick();
        check("tt1_ackoff", 32'(ack),  32'h0);
        check("tt1_gntoff", 32'(gnt),  32'h0);
        check("tt1_idle",   32'(busy), 32'h0);
        set_cmd(0, 8'hFF, 8'hFF);
        one_tx(0, 8'h0F, "tt2");
        tick();
        check("tt2_noack", 32'(ack), 32'h0);

        // clr during APPLY of requester 1 (ptr=1)
        set_cmd(1, 8'hFF, 8'h00);
        req = 4'b0010;
        tick();
        check("clr_gnt", 32'(gnt), 32'h2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_q",   32'(q),   32'h00);
        check("clr_ack", 32'(ack), 32'h2);
        req = 4'b0000;
        tick();

        // Late command change during APPLY is ignored (ptr=2)
        set_cmd(2, 8'h3C, 8'h00);
        req = 4'b0100;
        tick();
        check("late_gnt", 32'(gnt), 32'h4);
        set_cmd(2, 8'hFF, 8'h00);
        tick();
        check("late_q", 32'(q), 32'h3C);
        req = 4'b0000;
        tick();

        // Build q=AA then clear in IDLE (ptr=3)
        set_cmd(3, 8'hAA, 8'h55);
        one_tx(3, 8'hAA, "aa");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("idleclr_q",    32'(q),    32'h00);
        check("idleclr_busy", 32'(busy), 32'h0);

        // ptr -> 2, q -> FF, then abort a requester-2 transaction with rst
        set_cmd(1, 8'hFF, 8'h00);
        one_tx(1, 8'hFF, "pre");
        req = 4'b0100;
        tick();
        check("abort_gnt", 32'(gnt), 32'h4);
        rst = 1'b1;
        #1;
        check("abort_gnt0",  32'(gnt),  32'h0);
        check("abort_busy0", 32'(busy), 32'h0);
        check("abort_q0",    32'(q),    32'h00);
        tick();
        check("abort_ack", 32'(ack), 32'h0);
        rst = 1'b0;
        req = 4'b0101;
        tick();
        check("post_rst_gnt", 32'(gnt), 32'h1);
        tick();
        check("post_rst_ack", 32'(ack), 32'h1);
        req = 4'b0000;
        tick();
        req = 4'b0100;
        tick();
        check("post_rst_gnt2", 32'(gnt), 32'h4);
        tick();
        req = 4'b0000;
        tick();

        // Fairness and wrap with all requests held
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            exp_g = 4'b0001 << (i % 4);
            tick();
            check("rr_gnt", 32'(gnt), 32'(exp_g));
            tick();
            check("rr_ack", 32'(ack), 32'(exp_g));
            tick();
            check("rr_ackoff", 32'(ack), 32'h0);
        end
        req = 4'b0000;
        tick();

        // Lock behaviour on req=0011 with lock[0] held for two ACKs
`ifdef JK_ARB_LOCK_EN
        exp_lock[0] = 4'b0001; exp_lock[1] = 4'b0001; exp_lock[2] = 4'b0001; exp_lock[3] = 4'b0010;
`else
        exp_lock[0] = 4'b0001; exp_lock[1] = 4'b0010; exp_lock[2] = 4'b0001; exp_lock[3] = 4'b0010;
`endif
        do_reset();
        req  = 4'b0011;
        lock = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lock_gnt", 32'(gnt), 32'(exp_lock[i]));
            if (i == 2) lock = 4'b0000;
            else        lock = lock;
            tick();
            tick();
        end
        req = 4'b0000;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
